fifo_wr_arbiter: RTL and testbench

Round-robin, packet-locking write arbiter that shares the write port of one FIFO (its push/din/full side) between N_REQ requesters. It grants one requester at a time and holds the grant until that requester's last beat, so packets are never interleaved in the FIFO. A watchdog releases a grant whose owner stalls. The block sits in the FIFO's write-clock domain and drives its push and din inputs directly.

---
 rtl/fifo_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, packet-locking write arbiter for one FIFO
// write port. A grant is held until the owner's last beat transfers, or
// until the watchdog releases an owner that has stopped presenting data.
module fifo_wr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_last,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   push,
  output logic [WIDTH-1:0]       din,
  input  logic                   full,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   abort
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    idle_cnt_q, idle_cnt_d;
  logic             abort_q, abort_d;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic             owner_valid;
  logic             owner_last;
  logic [IDW-1:0]   owner_inc;
  logic             sel_found;
  logic [IDW-1:0]   sel_id;

  // Split the flat data bus into one word per requester
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
    assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign owner_inc   = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

  assign grant_id = owner_q;
  assign busy     = (state_q == LOCK);
  assign abort    = abort_q;

  // Round-robin search: first valid index starting at rr_ptr, wrapping
  always_comb begin
    int cand_int;
    logic [IDW-1:0] cand;
    sel_found = 1'b0;
    sel_id    = rr_ptr_q;
    cand_int  = 0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_int = (int'(rr_ptr_q) + i) % N_REQ;
      cand     = IDW'(cand_int);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Next-state, watchdog and write-port outputs
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    abort_d    = 1'b0;
    req_ready  = '0;
    push       = 1'b0;
    din        = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = LOCK;
          owner_d    = sel_id;
          idle_cnt_d = '0;
        end
      end
      LOCK: begin
        // Only the owner sees ready; ready never depends on valid
        req_ready[owner_q] = ~full;
        push               = owner_valid & ~full;
        din                = data_arr[owner_q];
        if (owner_valid) begin
          // A valid owner held off by full is not idle
          idle_cnt_d = '0;
          if (push && owner_last) begin
            state_d  = IDLE;
            rr_ptr_d = owner_inc;
          end
        end else if (idle_cnt_q == CNT_MAX) begin
          state_d    = IDLE;
          rr_ptr_d   = owner_inc;
          abort_d    = 1'b1;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      abort_q    <= abort_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle vectors with expected outputs, plus a
// scoreboard of expected FIFO words checked against every observed push.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0] req_ready;
  logic         push;
  logic [W-1:0] din;
  logic         full;
  logic [1:0]   grant_id;
  logic         busy;
  logic         abort;

  fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .push(push), .din(din),
    .full(full), .grant_id(grant_id), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic       p;
    logic [3:0] r;
    logic [1:0] g;
    logic       b;
    logic       a;
    logic [7:0] d;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];
  int         beat_cnt[N];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         row      = 0;

  function automatic vec_t mk(logic rs, logic [3:0] v, logic [3:0] l, logic f,
                              logic p, logic [3:0] r, logic [1:0] g,
                              logic b, logic a, logic [7:0] d);
    vec_t t;
    t.rs = rs; t.v = v; t.l = l; t.f = f;
    t.p = p; t.r = r; t.g = g; t.b = b; t.a = a; t.d = d;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check settled outputs, then let the
  // requester models advance their beat counters on accepted handshakes.
  task automatic step(input vec_t t);
    logic [N-1:0] hs;
    logic [7:0]   exp_d;
    @(negedge clk);
    rstn      = t.rs;
    req_valid = t.v;
    req_last  = t.l;
    full      = t.f;
    for (int i = 0; i < N; i++)
      req_data[i*W +: W] = {4'(i), 4'(beat_cnt[i])};
    if (t.p) sb_q.push_back(t.d);
    #1;
    chk("push", 32'(push), 32'(t.p));
    chk("req_ready", 32'(req_ready), 32'(t.r));
    chk("grant_id", 32'(grant_id), 32'(t.g));
    chk("busy", 32'(busy), 32'(t.b));
    chk("abort", 32'(abort), 32'(t.a));
    if (push === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL row %0d din: unexpected push of %h, none expected", row, din);
      end else begin
        exp_d = sb_q.pop_front();
        $display("row %0d push gid=%0d din=%h exp=%h", row, grant_id, din, exp_d);
        chk("din", 32'(din), 32'(exp_d));
      end
    end
    hs = req_valid & req_ready;
    @(posedge clk);
    for (int i = 0; i < N; i++)
      if (hs[i]) beat_cnt[i]++;
    row++;
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'h0;
    req_data  = '0;
    full      = 1'b0;
    for (int i = 0; i < N; i++) beat_cnt[i] = 0;

    // Reset held with every requester valid
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    // Fair rotation, 2-beat packets, bubble between packets, wrap to 0
    vecs.push_back(mk(1, 4'hF, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h0, 0, 1, 4'h1, 0, 1, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h1, 0, 1, 4'h1, 0, 1, 0, 8'h01));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h0, 0, 1, 4'h2, 1, 1, 0, 8'h10));
    vecs.push_back(mk(1, 4'hF, 4'h2, 0, 1, 4'h2, 1, 1, 0, 8'h11));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h0, 0, 1, 4'h4, 2, 1, 0, 8'h20));
    vecs.push_back(mk(1, 4'hF, 4'h4, 0, 1, 4'h4, 2, 1, 0, 8'h21));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 2, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h0, 0, 1, 4'h8, 3, 1, 0, 8'h30));
    vecs.push_back(mk(1, 4'hF, 4'h8, 0, 1, 4'h8, 3, 1, 0, 8'h31));
    vecs.push_back(mk(1, 4'hF, 4'hF, 0, 0, 4'h0, 3, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hF, 4'h0, 0, 1, 4'h1, 0, 1, 0, 8'h02));
    vecs.push_back(mk(1, 4'hF, 4'h1, 0, 1, 4'h1, 0, 1, 0, 8'h03));
    // Packet lock: req1 sends 4 beats while req2/req3 wait
    vecs.push_back(mk(1, 4'hE, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hE, 4'h0, 0, 1, 4'h2, 1, 1, 0, 8'h12));
    vecs.push_back(mk(1, 4'hE, 4'h0, 0, 1, 4'h2, 1, 1, 0, 8'h13));
    vecs.push_back(mk(1, 4'hE, 4'h0, 0, 1, 4'h2, 1, 1, 0, 8'h14));
    vecs.push_back(mk(1, 4'hE, 4'h2, 0, 1, 4'h2, 1, 1, 0, 8'h15));
    // Backpressure: req2 3-beat packet, full for 5 cycles on beat 2
    vecs.push_back(mk(1, 4'hC, 4'h0, 0, 0, 4'h0, 1, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'hC, 4'h0, 0, 1, 4'h4, 2, 1, 0, 8'h22));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 4'hC, 4'h0, 1, 0, 4'h0, 2, 1, 0, 8'h00));
    vecs.push_back(mk(1, 4'hC, 4'h0, 0, 1, 4'h4, 2, 1, 0, 8'h23));
    vecs.push_back(mk(1, 4'hC, 4'h4, 0, 1, 4'h4, 2, 1, 0, 8'h24));
    // Watchdog: req3 sends one non-last beat then goes silent for 16 cycles
    vecs.push_back(mk(1, 4'h8, 4'h0, 0, 0, 4'h0, 2, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h8, 4'h0, 0, 1, 4'h8, 3, 1, 0, 8'h32));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h8, 3, 1, 0, 8'h00));
    vecs.push_back(mk(1, 4'h1, 4'h0, 0, 0, 4'h0, 3, 0, 1, 8'h00));
    vecs.push_back(mk(1, 4'h1, 4'h1, 0, 1, 4'h1, 0, 1, 0, 8'h04));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    // Single-beat req3, then req0 after wrap
    vecs.push_back(mk(1, 4'h8, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h8, 4'h8, 0, 1, 4'h8, 3, 1, 0, 8'h33));
    vecs.push_back(mk(1, 4'h1, 4'h0, 0, 0, 4'h0, 3, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h1, 4'h1, 0, 1, 4'h1, 0, 1, 0, 8'h05));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    // full during a single last beat: held in LOCK until it transfers
    vecs.push_back(mk(1, 4'h2, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    vecs.push_back(mk(1, 4'h2, 4'h2, 1, 0, 4'h0, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 4'h2, 4'h2, 0, 1, 4'h2, 1, 1, 0, 8'h16));
    vecs.push_back(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 1, 0, 0, 8'h00));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset in the middle of a req2 packet: partial packet abandoned
    step(mk(1, 4'h4, 4'h0, 0, 0, 4'h0, 1, 0, 0, 8'h00));
    step(mk(1, 4'h4, 4'h0, 0, 1, 4'h4, 2, 1, 0, 8'h25));
    step(mk(0, 4'h0, 4'h0, 0, 0, 4'h4, 2, 1, 0, 8'h00));
    step(mk(1, 4'h4, 4'h0, 0, 0, 4'h0, 0, 0, 0, 8'h00));
    step(mk(1, 4'h4, 4'h4, 0, 1, 4'h4, 2, 1, 0, 8'h26));
    step(mk(1, 4'h0, 4'h0, 0, 0, 4'h0, 2, 0, 0, 8'h00));

    chk("scoreboard_left", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
